ccff_chain_loader: RTL and testbench

//  Transmit end of the configuration chain: serializes bitstream words into ccff_head of the

---
 rtl/ccff_chain_loader_pkg.sv | 12 +
 rtl/ccff_chain_loader_if.sv | 11 +
 rtl/ccff_chain_loader_word_serializer.sv | 45 ++++
 rtl/ccff_chain_loader.sv | 74 +++++++
 tb/tb_ccff_chain_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_chain_loader_pkg;
  localparam int WORD_W_DEF    = 32;
  localparam int CHAIN_LEN_DEF = 1024;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  // Width of a counter that must hold every value 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ccff_chain_loader_if.sv
// Word handshake between the bitstream buffer (master) and the chain loader (slave).
interface ccff_chain_loader_if #(
  parameter int WORD_W = ccff_chain_loader_pkg::WORD_W_DEF
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader_word_serializer.sv
// Word-to-bit serializer: MSB first, registered head bit and chain clock enable.
module ccff_word_serializer
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                     prog_clk,
  input  logic                     pReset_n,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     flush,
  input  logic [WORD_W-1:0]        data,
  output logic [cnt_w(WORD_W)-1:0] rem,
  output logic                     ccff_head,
  output logic                     ccff_shift_en
);
  localparam int REM_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] shreg;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      shreg         <= '0;
      rem           <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else if (clear) begin
      rem           <= '0;
      ccff_shift_en <= 1'b0;
    end else begin
      ccff_shift_en <= (rem != '0);
      if (rem != '0) begin
        ccff_head <= shreg[WORD_W-1];
        shreg     <= {shreg[WORD_W-2:0], 1'b0};
        // Chain full: drop the pad bits still sitting in the LSBs.
        rem       <= flush ? '0 : rem - REM_W'(1);
      end
      // Loading while the last old bit leaves keeps back-to-back words gapless.
      if (load) begin
        shreg <= data;
        rem   <= REM_W'(WORD_W);
      end
    end
  end
endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration chain loader: feeds CHAIN_LEN bits into ccff_head and watches ccff_tail.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic               prog_clk,
  input  logic               pReset_n,
  input  logic               start,
  ccff_chain_loader_if.slave s_if,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               tail_err
);
  localparam int CNT_W = cnt_w(CHAIN_LEN);
  localparam int REM_W = cnt_w(WORD_W);

  state_e           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [REM_W-1:0] rem;
  logic             go, shifting, hs, last;
  logic [31:0]      fill;

  assign go       = start && (state != LOAD);
  assign shifting = (rem != '0);
  assign last     = shifting && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // Bits already sent plus bits still queued; no new word once that covers the chain.
  assign fill        = 32'(bit_cnt) + 32'(rem);
  assign s_if.s_ready = (state == LOAD) && (rem <= REM_W'(1)) && (fill < 32'(CHAIN_LEN));
  assign hs          = s_if.s_valid && s_if.s_ready;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tail_err <= 1'b0;
    end else if (go) begin
      state    <= LOAD;
      bit_cnt  <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      tail_err <= 1'b0;
    end else begin
      // Chain was cleared by reset, so any 1 reaching the tail is a fault.
      if (ccff_shift_en && ccff_tail) tail_err <= 1'b1;
      if (state == LOAD) begin
        if (shifting) bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .clear         (go),
    .load          (hs),
    .flush         (last),
    .data          (s_if.s_data),
    .rem           (rem),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en)
  );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: scoreboard of expected chain bits, 70-bit and 32-bit chain instances.
module tb_ccff_chain_loader;
  localparam int W  = 32;
  localparam int L  = 70;
  localparam int L2 = 32;

  logic prog_clk = 1'b0;
  logic pReset_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.WORD_W(W)) a_if ();
  ccff_chain_loader_if #(.WORD_W(W)) b_if ();

  logic start_a, head_a, sen_a, tail_a, busy_a, done_a, err_a;
  logic start_b, head_b, sen_b, tail_b, busy_b, done_b, err_b;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_a), .s_if(a_if),
    .ccff_head(head_a), .ccff_shift_en(sen_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .tail_err(err_a));

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L2)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_b), .s_if(b_if),
    .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .tail_err(err_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] w [4];
  bit   q0 [$];
  bit   q1 [$];
  int   bits [2], words [2], pushed [2], first [2], last [2], done_cyc [2], s_cyc [2];
  bit   hs [2];
  int   err_cyc  = -1;
  int   force_at = -1;
  logic [L-1:0] chain = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes into the scoreboard, drive the chain tail, then
  // compare every bit the DUT puts on the chain head.
  task automatic tick();
    logic sa, ha, e;
    #1;
    hs[0] = a_if.s_valid && a_if.s_ready;
    hs[1] = b_if.s_valid && b_if.s_ready;
    if (hs[0]) begin
      words[0]++;
      for (int i = W - 1; i >= 0; i--)
        if (pushed[0] < L) begin q0.push_back(a_if.s_data[i]); pushed[0]++; end
    end
    if (hs[1]) begin
      words[1]++;
      for (int i = W - 1; i >= 0; i--)
        if (pushed[1] < L2) begin q1.push_back(b_if.s_data[i]); pushed[1]++; end
    end
    sa = sen_a;
    ha = head_a;
    tail_a = (sa && bits[0] == force_at) ? 1'b1 : chain[L-1];
    @(posedge prog_clk);
    #1;
    cyc++;
    if (sa) chain = {chain[L-2:0], ha};
    if (sen_a) begin
      bits[0]++;
      if (first[0] < 0) first[0] = cyc;
      last[0] = cyc;
      if (q0.size() > 0) e = q0.pop_front(); else e = 1'bz;
      check("head_a", head_a, e);
    end
    if (sen_b) begin
      bits[1]++;
      if (first[1] < 0) first[1] = cyc;
      last[1] = cyc;
      if (q1.size() > 0) e = q1.pop_front(); else e = 1'bz;
      check("head_b", head_b, e);
    end
    if (done_a && done_cyc[0] < 0) done_cyc[0] = cyc;
    if (done_b && done_cyc[1] < 0) done_cyc[1] = cyc;
    if (err_a && err_cyc < 0) err_cyc = cyc;
    @(negedge prog_clk);
  endtask

  task automatic begin_load(input int d);
    if (d == 0) begin q0.delete(); chain = '0; err_cyc = -1; start_a = 1'b1; end
    else begin q1.delete(); start_b = 1'b1; end
    pushed[d] = 0; words[d] = 0; bits[d] = 0;
    first[d] = -1; last[d] = -1; done_cyc[d] = -1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    s_cyc[d] = cyc;
  endtask

  // Source model: words w[0..3] in order, optionally gated by a 3-on/3-off valid.
  task automatic run(input int d, input bit toggle, input bit mid_start,
                     input int stop_bits, input int budget);
    int  widx = 0;
    int  n    = 0;
    bit  vld;
    while (!(d == 0 ? done_a : done_b) && bits[d] < stop_bits && n < budget) begin
      vld = !toggle || ((n / 3) % 2 == 0);
      if (d == 0) begin
        a_if.s_data = w[widx]; a_if.s_valid = vld; start_a = mid_start && n == 10;
      end else begin
        b_if.s_data = w[widx]; b_if.s_valid = vld;
      end
      tick();
      n++;
      if (d == 1 && hs[1]) check("b_ready_after_hs", b_if.s_ready, 0);
      if (hs[d] && widx < 3) widx++;
    end
    a_if.s_valid = 1'b0;
    b_if.s_valid = 1'b0;
    start_a      = 1'b0;
    check("run_within_budget", n < budget, 1);
  endtask

  task automatic check_load(input int d, input int len, input int nwords);
    check("bit_count",    bits[d], len);
    check("sb_drained",   (d == 0 ? q0.size() : q1.size()), 0);
    check("words_used",   words[d], nwords);
    check("done_high",    (d == 0 ? done_a : done_b), 1);
    check("done_latency", done_cyc[d], last[d] + 1);
    check("first_bit_lat", first[d], s_cyc[d] + 2);
    check("busy_low",     (d == 0 ? busy_a : busy_b), 0);
    check("shift_en_low", (d == 0 ? sen_a : sen_b), 0);
    check("ready_low",    (d == 0 ? a_if.s_ready : b_if.s_ready), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    w[0] = 32'hA5C3_0F96; w[1] = 32'h1234_5678;
    w[2] = 32'hB7FF_FFFF; w[3] = 32'hDEAD_BEEF;
    for (int d = 0; d < 2; d++) begin
      bits[d] = 0; words[d] = 0; pushed[d] = 0; first[d] = -1; last[d] = -1; done_cyc[d] = -1;
      hs[d] = 1'b0; s_cyc[d] = 0;
    end
    start_a = 1'b0; start_b = 1'b0; tail_a = 1'b0; tail_b = 1'b0;
    a_if.s_data = '0; a_if.s_valid = 1'b0;
    b_if.s_data = '0; b_if.s_valid = 1'b0;
    repeat (2) @(negedge prog_clk);

    // Reset state
    check("rst_head",  head_a, 0);
    check("rst_sen",   sen_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_err",   err_a, 0);
    check("rst_ready", a_if.s_ready, 0);
    check("rst_b_ready", b_if.s_ready, 0);
    pReset_n = 1'b1;
    tick();

    // s_valid in IDLE is ignored
    a_if.s_data = w[0]; a_if.s_valid = 1'b1;
    repeat (3) tick();
    a_if.s_valid = 1'b0;
    check("idle_no_consume", words[0], 0);
    check("idle_not_busy", busy_a, 0);

    // Test 1: continuous source, gapless 70 bits from 3 words
    begin_load(0);
    run(0, 1'b0, 1'b0, 1000, 300);
    check_load(0, L, 3);
    check("gapless", last[0] - first[0] + 1, L);

    // s_valid in DONE is ignored
    a_if.s_data = w[3]; a_if.s_valid = 1'b1;
    repeat (3) tick();
    a_if.s_valid = 1'b0;
    check("done_no_consume", words[0], 3);
    check("done_holds", done_a, 1);

    // Test 2: starved source plus a start pulse mid-load
    begin_load(0);
    run(0, 1'b1, 1'b1, 1000, 400);
    check_load(0, L, 3);
    check("starved_gaps", (last[0] - first[0] + 1) > L, 1);

    // Test 3: tail fault on shift 40, sticky through DONE, cleared by start
    force_at = 40;
    begin_load(0);
    run(0, 1'b0, 1'b0, 1000, 300);
    check_load(0, L, 3);
    check("tail_err_set", err_a, 1);
    check("tail_err_when", err_cyc, first[0] + 40);
    repeat (3) tick();
    check("tail_err_sticky", err_a, 1);
    force_at = -1;
    begin_load(0);
    check("tail_err_clr", err_a, 0);
    check("restart_busy", busy_a, 1);

    // Test 4: reset after 20 bits, then full reload
    force_at = 5;
    run(0, 1'b0, 1'b0, 20, 100);
    force_at = -1;
    check("pre_rst_bits", bits[0], 20);
    check("pre_rst_err", err_a, 1);
    pReset_n = 1'b0;
    #1;
    check("mid_rst_head",  head_a, 0);
    check("mid_rst_sen",   sen_a, 0);
    check("mid_rst_busy",  busy_a, 0);
    check("mid_rst_done",  done_a, 0);
    check("mid_rst_err",   err_a, 0);
    check("mid_rst_ready", a_if.s_ready, 0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    tick();
    begin_load(0);
    run(0, 1'b0, 1'b0, 1000, 300);
    check_load(0, L, 3);

    // Test 6: chain length equal to one word
    begin_load(1);
    run(1, 1'b0, 1'b0, 1000, 200);
    check_load(1, L2, 1);
    check("b_gapless", last[1] - first[1] + 1, L2);
    check("b_err", err_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
